// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding for the sequential units and
// the opcode that selects the MOD input of the per-bit result muxes.
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Select code of the MOD leg on the 8-to-1 result mux.
  localparam logic [2:0] ALU_OP_MOD = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } mod_state_t;

endpackage

// File: rtl/mod_unit_if.sv
// Request/response bundle between the ALU control path and the MOD unit.
interface mod_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] quotient;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (output start, a, b,
                  input  result, quotient, busy, done, div_by_zero);
  modport slave  (input  start, a, b,
                  output result, quotient, busy, done, div_by_zero);
endinterface

// File: rtl/mod_unit_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference if it
// did not borrow.
module mod_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvsr,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;
  // Remainder stays below the divisor, so its top bit is always zero and
  // drops out of the shift.
  logic           w_unused_msb;

  assign w_unused_msb = i_rem[WIDTH];
  assign w_shift      = {i_rem[WIDTH-1:0], i_bit};
  assign w_trial      = w_shift - {1'b0, i_dvsr};

  // Top bit of the trial difference is the borrow.
  always_comb begin
    o_qbit = ~w_trial[WIDTH];
    o_rem  = w_trial[WIDTH] ? w_shift : w_trial;
  end
endmodule

// File: rtl/mod_unit.sv
// Sequential unsigned divider feeding the MOD leg of the result muxes.
// One quotient bit per clock, WIDTH+1 cycles start-to-done; result and
// quotient registers only change on completion so the mux input is stable.
module mod_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  mod_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  mod_state_t       r_state, w_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_quot;
  logic [CW-1:0]    r_cnt;
  logic             r_dbz;

  logic [WIDTH:0]   w_rem_nxt;
  logic             w_qbit;
  logic             w_accept;
  logic             w_zero;
  logic             w_last;

  mod_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  assign w_zero = (bus.b == '0);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and start acceptance; a zero divisor skips RUN entirely.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = w_zero ? S_DONE : S_RUN;
        end else if (r_state == S_DONE) begin
          w_next = S_IDLE;
        end
      end
      S_RUN:   if (w_last) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: load operands on accept, iterate in RUN, publish on the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvsr   <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_dbz    <= 1'b0;
      r_result <= '0;
      r_quot   <= '0;
    end else if (w_accept) begin
      r_dvd  <= bus.a;
      r_dvsr <= bus.b;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_dbz  <= w_zero;
      if (w_zero) begin
        r_result <= bus.a;
        r_quot   <= '1;
      end
    end else if (r_state == S_RUN) begin
      r_rem <= w_rem_nxt;
      r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
      r_q   <= {r_q[WIDTH-2:0], w_qbit};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= w_rem_nxt[WIDTH-1:0];
        r_quot   <= {r_q[WIDTH-2:0], w_qbit};
      end
    end
  end

  assign bus.result      = r_result;
  assign bus.quotient    = r_quot;
  assign bus.busy        = (r_state == S_RUN);
  assign bus.done        = (r_state == S_DONE);
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_mod_unit.sv
// Bench for mod_unit: an operation-level reference (a % b, a / b, countdown
// to completion) checked against the DUT every cycle, plus literal checks.
module tb_mod_unit;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mod_unit_if #(.WIDTH(W)) bus();

  mod_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: what the unit must show after each clock edge.
  logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [W-1:0] m_res = '0, m_quo = '0, m_pres = '0, m_pquo = '0;
  int           m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
      m_res  = '0;   m_quo  = '0;   m_left = 0;
    end else if (bus.start && !m_busy) begin
      m_dbz = (bus.b == '0);
      if (bus.b == '0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_res  = bus.a; m_quo = '1;
      end else begin
        m_busy = 1'b1; m_done = 1'b0; m_left = W;
        m_pres = bus.a % bus.b;
        m_pquo = bus.a / bus.b;
      end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_res  = m_pres; m_quo = m_pquo;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare every output with the reference.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("busy",     W'(bus.busy),        W'(m_busy));
    chk("done",     W'(bus.done),        W'(m_done));
    chk("dbz",      W'(bus.div_by_zero), W'(m_dbz));
    chk("result",   bus.result,          m_res);
    chk("quotient", bus.quotient,        m_quo);
  endtask

  // Issue one start in the current cycle and count cycles until done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    bus.start = 1'b1; bus.a = a; bus.b = b;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  int lat;

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_result", bus.result, 32'd0);
    chk("rst_busy",   W'(bus.busy), 32'd0);
    tick();

    run_op(32'd17, 32'd5, lat);
    chk("t1_lat", W'(lat), 32'd33);
    chk("t1_res", bus.result, 32'd2);
    chk("t1_quo", bus.quotient, 32'd3);
    chk("t1_dbz", W'(bus.div_by_zero), 32'd0);
    tick(); tick();

    run_op(32'd5, 32'd17, lat);
    chk("t2_res", bus.result, 32'd5);
    chk("t2_quo", bus.quotient, 32'd0);
    tick();
    run_op(32'hFFFF_FFFF, 32'h10, lat);
    chk("t3_res", bus.result, 32'hF);
    chk("t3_quo", bus.quotient, 32'h0FFF_FFFF);
    tick();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("t4_res", bus.result, 32'd0);
    chk("t4_quo", bus.quotient, 32'd1);
    tick();

    run_op(32'd9, 32'd0, lat);
    chk("dz_lat", W'(lat), 32'd1);
    chk("dz_res", bus.result, 32'd9);
    chk("dz_quo", bus.quotient, 32'hFFFF_FFFF);
    chk("dz_flag", W'(bus.div_by_zero), 32'd1);
    tick();
    chk("dz_hold", W'(bus.div_by_zero), 32'd1);
    bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd4;
    tick();
    bus.start = 1'b0;
    chk("dz_clear", W'(bus.div_by_zero), 32'd0);
    chk("dz_held_res", bus.result, 32'd9);
    lat = 1;
    while (!bus.done && lat < 200) begin tick(); lat++; end
    chk("t5_res", bus.result, 32'd1);
    chk("t5_quo", bus.quotient, 32'd2);
    tick();

    // Start pulse during RUN must be ignored.
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1;
    tick();
    bus.start = 1'b0;
    lat = 11;
    while (!bus.done && lat < 200) begin tick(); lat++; end
    chk("ign_lat", W'(lat), 32'd33);
    chk("ign_res", bus.result, 32'd2);
    chk("ign_quo", bus.quotient, 32'd14);
    tick();

    // Reset in the middle of RUN discards the operation.
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_res",  bus.result, 32'd0);
    chk("mrst_quo",  bus.quotient, 32'd0);
    chk("mrst_busy", W'(bus.busy), 32'd0);
    repeat (40) tick();
    chk("mrst_nodone", W'(bus.done), 32'd0);
    run_op(32'd20, 32'd6, lat);
    chk("mrst_lat", W'(lat), 32'd33);
    chk("mrst_new", bus.result, 32'd2);

    // Back-to-back: start issued in the done cycle.
    run_op(32'd50, 32'd8, lat);
    chk("b2b_lat", W'(lat), 32'd33);
    chk("b2b_res", bus.result, 32'd2);
    chk("b2b_quo", bus.quotient, 32'd6);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mod_unit.md
# mod_unit

Sequential unsigned remainder unit for the ALU's MOD operation.
- Sits directly upstream of the per-bit 8-to-1 result multiplexers: bit i of `result` drives the MOD input of bit-slice i's mux.
- Computes `a mod b` (and `a / b`) by restoring shift-subtract, one quotient bit per clock, with fixed latency.
- Issues a one-cycle completion pulse so the control path knows when the mux input is valid.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥2)
- `clk`  input  1  rising-edge clock; only clock
- `reset`  input  1  synchronous, active-high reset
- `start`  input  1  request; sampled only when `busy`=0
- `a`  input  WIDTH  dividend, unsigned; captured on accepted start
- `b`  input  WIDTH  divisor, unsigned; captured on accepted start
- `result`  output  WIDTH  remainder `a mod b`; registered
- `quotient`  output  WIDTH  `a / b`; registered
- `busy`  output  1  high while iterating
- `done`  output  1  one-cycle pulse: result/quotient valid
- `div_by_zero`  output  1  set with `done` when captured `b`=0; held until next accepted start

## Operation
- FSM states and transitions:
  - IDLE -> RUN on `start` when captured `b`≠0; IDLE -> DONE on `start` when `b`=0.
  - RUN -> DONE after exactly WIDTH iterations.
  - DONE -> IDLE, or DONE -> RUN/DONE if `start`=1 in the DONE cycle (back-to-back accepted).
- Start acceptance:
  - Accepted only in IDLE or DONE; ignored in RUN, with no effect on operands or count.
  - On accept: latch `a`→dividend shift register, `b`→divisor register; clear partial remainder (WIDTH+1 bits), iteration counter and `div_by_zero`.
- Each RUN cycle (one restoring step):
  - trial = {rem[WIDTH-1:0], dvd[WIDTH-1]} − {0, divisor}, WIDTH+1 bits.
  - No borrow: rem = trial and quotient bit 1. Borrow: rem = shifted value and quotient bit 0.
  - dvd shifts left, quotient shifts left with the new bit in the LSB.
- Leaving RUN: load `result` = rem[WIDTH-1:0] and `quotient` in the same edge that enters DONE.
- Divide-by-zero: `result` = captured `a`, `quotient` = all ones, `div_by_zero` = 1.
- Output hold: `result`/`quotient` hold their value until the next completion. They are not cleared on start, so the mux input stays stable.
- Reset (any state, including mid-RUN):
  - State -> IDLE; all outputs 0; the in-flight operation is discarded.
  - Only the next accepted start leads to a `done`.

## Timing
- Cycle 0: `start`=1 with `busy`=0, accepted at the cycle-0 edge.
- Normal case: `busy`=1 in cycles 1..WIDTH; `done`=1 in cycle WIDTH+1 only, with `busy`=0; outputs valid from cycle WIDTH+1.
- Latency is fixed at WIDTH+1 cycles, start to done.
- `b`=0 case: `busy` never rises; `done`=1 in cycle 1.
- Back-to-back: `start` in a `done` cycle gives `busy` in the next cycle; throughput is one operation per WIDTH+1 cycles.
- `done` and `busy` are never high together.

## Structure
- Shared package `alu_pkg` holds:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the ALU opcode constant for MOD, so the control path and the mux select agree.
- One combinational sub-module `mod_step`: a (WIDTH+1)-bit trial subtract plus restore select. It takes rem, the incoming dividend bit and the divisor, and produces next rem and the quotient bit. Instantiated once.
- Counter width: $clog2(WIDTH)+1.

## Test plan
- a=17, b=5, start one cycle -> `busy` cycles 1..32, `done` cycle 33 only, `result`=2, `quotient`=3, `div_by_zero`=0.
- a=5, b=17 -> `result`=5, `quotient`=0; then a=0xFFFFFFFF, b=0x10 -> `result`=0xF, `quotient`=0x0FFFFFFF; then a=0xFFFFFFFF, b=0xFFFFFFFF -> `result`=0, `quotient`=1.
- a=9, b=0 -> `done` in cycle 1, `busy` never high, `result`=9, `quotient`=0xFFFFFFFF, `div_by_zero`=1. A following a=9, b=4 -> `div_by_zero` clears on accept, `result`=1.
- Start a=100, b=7; pulse `start` with a=1, b=1 in cycle 10 -> ignored; `done` in cycle 33 with `result`=2, `quotient`=14.
- Start a=100, b=7; assert `reset` in cycle 15 -> next cycle all outputs 0, state IDLE; no `done` until a new start (a=20, b=6 -> `result`=2).
- Assert `start` (a=50, b=8) in the `done` cycle of a previous op -> `busy` next cycle, `done` 33 cycles after that, `result`=2, `quotient`=6; previous `result` held throughout.
